index_decoder_bitmap: RTL and testbench
=======================================

// Module: index_decoder_bitmap
// PURPOSE
//  Inverse of the priority-encoder path: accepts a (has, idx) stream and emits a one-hot N-bit vector.
//  Also maintains a registered N-bit occupancy bitmap that is updated by per-beat SET/CLR/TOGGLE ops.
//  Sits downstream of the priority encoder in allocate/release loops: encoder picks a slot, this block marks or frees it.
//  Valid/ready on both sides; one register stage.
// PARAMETERS
//  N     64          vector/bitmap width (>=2; need not be a power of 2)
//  IDXW  $clog2(N)   index width
// PORTS
//  clk        in   1     clock, all state on rising edge
//  rst        in   1     asynchronous, active-high reset
//  in_valid   in   1     input beat valid
//  in_ready   out  1     input beat accepted when in_valid&&in_ready
//  in_has     in   1     index present (0 = empty beat)
//  in_idx     in   IDXW  bit index to decode
//  in_op      in   2     00 NOP, 01 SET, 10 CLR, 11 TOGGLE (bitmap op)
//  clear_all  in   1     synchronous bitmap clear, independent of handshake
//  out_valid  out  1     output beat valid
//  out_ready  in   1     downstream accepts when out_valid&&out_ready
//  out_onehot out  N     decoded one-hot (all-zero for empty/invalid beats)
//  out_err    out  1     beat had in_has=1 and in_idx>=N
//  map        out  N     occupancy bitmap
//  map_cnt    out  IDXW+1  popcount of map, registered
//  map_empty  out  1     map_cnt==0
//  map_full   out  1     map_cnt==N
// BEHAVIOUR
//  - Reset: out_valid=0, out_onehot=0, out_err=0, map=0, map_cnt=0, map_empty=1, map_full=0.
//  - Pipeline register: in_ready = !out_valid || out_ready (combinational on out_ready); latency 1 cycle.
//  - On accept: out_valid<=1; out_onehot<=(in_has && in_idx<N) ? 1<<in_idx : 0; out_err<=in_has && in_idx>=N.
//  - No accept and out_ready=1: out_valid<=0. Stalled output (out_valid&&!out_ready) holds all fields stable.
//  - Bitmap op applied on the accept edge only; has=0, err, or NOP leaves map unchanged.
//    SET: map[idx]<=1; CLR: map[idx]<=0; TOGGLE: map[idx]<=~map[idx]. SET on set bit / CLR on clear bit = no change.
//  - clear_all=1: map<=0 that cycle; if an accepted op coincides, op is applied to the cleared map
//    (SET/TOGGLE leaves exactly bit idx set; CLR leaves 0).
//  - map_cnt/map_empty/map_full updated in the same edge as map, always consistent with map (no extra latency).
//    map_cnt computed incrementally (+1/-1/0) from old bit value; clear_all forces base 0.
//  - Idx wrap not possible: idx>=N is an error beat, never aliased.
//  - Async reset mid-stall drops the pending output beat; no beat is replayed.
// CONFIGURATION
//  INDEX_DECODER_THERMO_EN defined: adds output out_thermo [N-1:0], registered with out_onehot,
//    = bits [idx:0] set (mask of idx and all lower); 0 for empty/err beats; reset 0.
//  Not defined: port and register absent; all other behaviour identical.
// TESTING (N=64)
//  1. Reset, in beat has=1 idx=5 op=SET -> next cycle out_onehot=64'h20, map=64'h20, map_cnt=1, map_empty=0.
//  2. out_ready=0, send idx=7 SET then idx=9 -> in_ready=0 on second beat, out_onehot holds 64'h80 until out_ready=1.
//  3. SET idx 0..63 back-to-back with out_ready=1 -> 1 beat/cycle, map=all-ones, map_cnt=64, map_full=1; CLR 63 -> cnt=63, full=0.
//  4. map=64'hF, clear_all=1 with accepted SET idx=40 -> map=1<<40, map_cnt=1.
//  5. has=0 beat -> out_onehot=0, out_err=0, map unchanged; N=48, idx=50 -> out_err=1, onehot=0, map unchanged.
//  6. THERMO_EN: idx=3 -> out_thermo=64'hF; assert rst mid-stall -> out_valid=0, map=0 immediately.

Source files
------------

// File: rtl/index_decoder_bitmap.sv
// Index-to-one-hot decoder with a registered occupancy bitmap updated by SET/CLR/TOGGLE beats.
// Optional thermometer output is enabled by defining INDEX_DECODER_THERMO_EN.
module index_decoder_bitmap #(
    parameter int N    = 64,
    parameter int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_has,
    input  logic [IDXW-1:0] in_idx,
    input  logic [1:0]      in_op,
    input  logic            clear_all,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_onehot,
    output logic            out_err,
`ifdef INDEX_DECODER_THERMO_EN
    output logic [N-1:0]    out_thermo,
`endif
    output logic [N-1:0]    map,
    output logic [IDXW:0]   map_cnt,
    output logic            map_empty,
    output logic            map_full
);

    localparam logic [IDXW:0] N_EXT = (IDXW+1)'(N);
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;

    // Handshake: a beat transfers on a side when valid && ready on the same rising edge;
    // valid never waits for ready, and a stalled output (out_valid && !out_ready) holds every field.
    logic            accept;
    logic            idx_ok;
    logic            bad_idx;
    logic [N-1:0]    dec_onehot;
    logic [N-1:0]    base_map;
    logic [IDXW:0]   base_cnt;
    logic            op_active;
    logic            old_bit;
    logic            new_bit;
    logic            cnt_inc;
    logic            cnt_dec;
    logic [N-1:0]    map_next;
    logic [IDXW:0]   cnt_next;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign bad_idx    = in_has && ({1'b0, in_idx} >= N_EXT);
    assign idx_ok     = in_has && !bad_idx;
    assign dec_onehot = idx_ok ? (N'(1) << in_idx) : '0;

    // clear_all zeroes the base first so a coincident op lands on an empty map.
    assign base_map  = clear_all ? '0 : map;
    assign base_cnt  = clear_all ? '0 : map_cnt;
    assign op_active = accept && idx_ok && (in_op != OP_NOP);
    assign old_bit   = |(base_map & dec_onehot);

    always_comb begin
        new_bit = old_bit;
        case (in_op)
            OP_SET:  new_bit = 1'b1;
            OP_CLR:  new_bit = 1'b0;
            OP_NOP:  new_bit = old_bit;
            default: new_bit = ~old_bit;
        endcase
    end

    assign cnt_inc  = op_active && new_bit && !old_bit;
    assign cnt_dec  = op_active && !new_bit && old_bit;
    assign map_next = !op_active ? base_map :
                      (new_bit ? (base_map | dec_onehot) : (base_map & ~dec_onehot));
    assign cnt_next = base_cnt + {{IDXW{1'b0}}, cnt_inc} - {{IDXW{1'b0}}, cnt_dec};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_onehot <= '0;
            out_err    <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_onehot <= dec_onehot;
            out_err    <= bad_idx;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
            out_onehot <= '0;
            out_err    <= 1'b0;
        end
    end

`ifdef INDEX_DECODER_THERMO_EN
    // Mask of idx and every lower bit; zero when no valid index is present.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_thermo <= '0;
        end else if (accept) begin
            out_thermo <= idx_ok ? (dec_onehot | (dec_onehot - N'(1))) : '0;
        end else if (out_ready) begin
            out_thermo <= '0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            map       <= '0;
            map_cnt   <= '0;
            map_empty <= 1'b1;
            map_full  <= 1'b0;
        end else begin
            map       <= map_next;
            map_cnt   <= cnt_next;
            map_empty <= (cnt_next == '0);
            map_full  <= (cnt_next == N_EXT);
        end
    end

endmodule

// File: tb/tb_index_decoder_bitmap.sv
// Directed bench for index_decoder_bitmap: a 64-wide instance plus a 48-wide instance for out-of-range indices.
// Thermometer checks are compiled in when INDEX_DECODER_THERMO_EN is defined.
module tb_index_decoder_bitmap;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_has;
    logic [5:0]  in_idx;
    logic [1:0]  in_op;
    logic        clear_all;
    logic        out_ready;

    logic        in_ready, out_valid, out_err, map_empty, map_full;
    logic [63:0] out_onehot, map;
    logic [6:0]  map_cnt;

    logic        in_ready48, out_valid48, out_err48, map_empty48, map_full48;
    logic [47:0] out_onehot48, map48;
    logic [6:0]  map_cnt48;
`ifdef INDEX_DECODER_THERMO_EN
    logic [63:0] out_thermo;
    logic [47:0] out_thermo48;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    index_decoder_bitmap #(.N(64)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_has(in_has),
        .in_idx(in_idx), .in_op(in_op), .clear_all(clear_all), .out_valid(out_valid),
        .out_ready(out_ready), .out_onehot(out_onehot), .out_err(out_err),
`ifdef INDEX_DECODER_THERMO_EN
        .out_thermo(out_thermo),
`endif
        .map(map), .map_cnt(map_cnt), .map_empty(map_empty), .map_full(map_full)
    );

    index_decoder_bitmap #(.N(48)) u_dut48 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready48), .in_has(in_has),
        .in_idx(in_idx), .in_op(in_op), .clear_all(clear_all), .out_valid(out_valid48),
        .out_ready(out_ready), .out_onehot(out_onehot48), .out_err(out_err48),
`ifdef INDEX_DECODER_THERMO_EN
        .out_thermo(out_thermo48),
`endif
        .map(map48), .map_cnt(map_cnt48), .map_empty(map_empty48), .map_full(map_full48)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic has, input logic [5:0] idx, input logic [1:0] op);
        in_valid = 1'b1;
        in_has   = has;
        in_idx   = idx;
        in_op    = op;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_has   = 1'b0;
        in_idx   = '0;
        in_op    = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        clear_all = 1'b0;
        out_ready = 1'b1;
        idle();
        tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_onehot", out_onehot, 64'd0);
        check("rst_err", 64'(out_err), 64'd0);
        check("rst_map", map, 64'd0);
        check("rst_cnt", 64'(map_cnt), 64'd0);
        check("rst_empty", 64'(map_empty), 64'd1);
        check("rst_full", 64'(map_full), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        tick();

        // single SET beat, one-cycle latency
        beat(1'b1, 6'd5, 2'b01);
        tick();
        idle();
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_onehot", out_onehot, 64'h20);
        check("t1_map", map, 64'h20);
        check("t1_cnt", 64'(map_cnt), 64'd1);
        check("t1_empty", 64'(map_empty), 64'd0);
        tick();
        check("t1_drain", 64'(out_valid), 64'd0);

        // backpressure: second beat waits, first output holds
        out_ready = 1'b0;
        beat(1'b1, 6'd7, 2'b01);
        tick();
        check("t2_onehot7", out_onehot, 64'h80);
        beat(1'b1, 6'd9, 2'b01);
        #1;
        check("t2_in_ready_low", 64'(in_ready), 64'd0);
        tick();
        check("t2_hold_onehot", out_onehot, 64'h80);
        check("t2_hold_valid", 64'(out_valid), 64'd1);
        check("t2_hold_map", map, 64'hA0);
        tick();
        check("t2_hold2_onehot", out_onehot, 64'h80);
        out_ready = 1'b1;
        #1;
        check("t2_in_ready_high", 64'(in_ready), 64'd1);
        tick();
        idle();
        check("t2_onehot9", out_onehot, 64'h200);
        check("t2_map", map, 64'h2A0);
        check("t2_cnt", 64'(map_cnt), 64'd3);
        tick();
        check("t2_drain", 64'(out_valid), 64'd0);

        // fill every slot back-to-back
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        check("t3_cleared", map, 64'd0);
        check("t3_cleared_empty", 64'(map_empty), 64'd1);
        for (int i = 0; i < 64; i++) begin
            beat(1'b1, 6'(i), 2'b01);
            #1;
            check("t3_in_ready", 64'(in_ready), 64'd1);
            tick();
            check("t3_onehot", out_onehot, 64'd1 << i);
        end
        idle();
        check("t3_map_full", map, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t3_cnt64", 64'(map_cnt), 64'd64);
        check("t3_full", 64'(map_full), 64'd1);
        beat(1'b1, 6'd63, 2'b10);
        tick();
        check("t3_clr63_map", map, 64'h7FFF_FFFF_FFFF_FFFF);
        check("t3_clr63_cnt", 64'(map_cnt), 64'd63);
        check("t3_clr63_full", 64'(map_full), 64'd0);
        tick();
        check("t3_clr_again_cnt", 64'(map_cnt), 64'd63);
        beat(1'b1, 6'd62, 2'b11);
        tick();
        check("t3_tog62_map", map, 64'h3FFF_FFFF_FFFF_FFFF);
        check("t3_tog62_cnt", 64'(map_cnt), 64'd62);
        beat(1'b1, 6'd10, 2'b01);
        tick();
        check("t3_set_set_cnt", 64'(map_cnt), 64'd62);
        idle();

        // clear_all coinciding with ops
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, 6'(i), 2'b01);
            tick();
        end
        check("t4_map_f", map, 64'hF);
        check("t4_cnt4", 64'(map_cnt), 64'd4);
        clear_all = 1'b1;
        beat(1'b1, 6'd40, 2'b01);
        tick();
        check("t4_clr_set_map", map, 64'd1 << 40);
        check("t4_clr_set_cnt", 64'(map_cnt), 64'd1);
        check("t4_clr_set_map48", 64'(map48), 64'd1 << 40);
        beat(1'b1, 6'd40, 2'b10);
        tick();
        check("t4_clr_clr_map", map, 64'd0);
        check("t4_clr_clr_empty", 64'(map_empty), 64'd1);
        beat(1'b1, 6'd2, 2'b11);
        tick();
        check("t4_clr_tog_map", map, 64'h4);
        check("t4_clr_tog_cnt", 64'(map_cnt), 64'd1);
        idle();
        tick();
        clear_all = 1'b0;
        check("t4_clr_only", map, 64'd0);
        beat(1'b1, 6'd2, 2'b11);
        tick();
        check("t4_tog_map", map, 64'h4);

        // empty beat, NOP beat and out-of-range index
        beat(1'b0, 6'd3, 2'b01);
        tick();
        check("t5_empty_valid", 64'(out_valid), 64'd1);
        check("t5_empty_onehot", out_onehot, 64'd0);
        check("t5_empty_err", 64'(out_err), 64'd0);
        check("t5_empty_map", map, 64'h4);
        beat(1'b1, 6'd3, 2'b00);
        tick();
        check("t5_nop_onehot", out_onehot, 64'h8);
        check("t5_nop_map", map, 64'h4);
        beat(1'b1, 6'd50, 2'b01);
        tick();
        check("t5_err48", 64'(out_err48), 64'd1);
        check("t5_onehot48", 64'(out_onehot48), 64'd0);
        check("t5_map48", 64'(map48), 64'h4);
        check("t5_cnt48", 64'(map_cnt48), 64'd1);
        check("t5_err64", 64'(out_err), 64'd0);
        check("t5_map64", map, 64'h4 | (64'd1 << 50));
        check("t5_cnt64", 64'(map_cnt), 64'd2);

`ifdef INDEX_DECODER_THERMO_EN
        beat(1'b1, 6'd3, 2'b01);
        tick();
        check("t6_thermo3", out_thermo, 64'hF);
        beat(1'b1, 6'd50, 2'b00);
        tick();
        check("t6_thermo_err48", 64'(out_thermo48), 64'd0);
`endif

        // async reset during a stall
        out_ready = 1'b0;
        beat(1'b1, 6'd7, 2'b01);
        tick();
        idle();
        check("t6_stall_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_map", map, 64'd0);
        check("t6_rst_cnt", 64'(map_cnt), 64'd0);
        check("t6_rst_empty", 64'(map_empty), 64'd1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t6_no_replay", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
